nios2_ocimem_ctrl: RTL and testbench
====================================

Name: nios2_ocimem_ctrl

Overview:
- Downstream consumer of the JTAG debug module's system-clock outputs (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a).
- Owns the on-chip debug memory (OCI RAM) and the MonAReg address register.
- Executes JTAG-issued reads and writes, and returns MonDReg, monitor_ready and monitor_error to the JTAG debug module.
- Also exposes a CPU-side Avalon-MM slave to the same RAM; JTAG commands have priority over the CPU.

Parameters:
- ADDR_W, 8, OCI RAM word-address width; depth is 2**ADDR_W 32-bit words.
- MONDREG_RST, 32'h0, reset value of MonDReg.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- jdo  in  38  JTAG data from the debug module, clk domain, valid while a take_* strobe is high
- take_action_ocimem_a  in  1  one-cycle strobe: address/read command
- take_action_ocimem_b  in  1  one-cycle strobe: write command
- take_no_action_ocimem_a  in  1  one-cycle strobe: read at MonAReg with post-increment
- address  in  ADDR_W  CPU slave word address
- read  in  1  CPU read request
- write  in  1  CPU write request
- writedata  in  32  CPU write data
- byteenable  in  4  CPU byte lanes
- debugaccess  in  1  CPU write permission
- readdata  out  32  CPU read data, read latency 1
- waitrequest  out  1  CPU stall
- MonDReg  out  32  last JTAG read or write data
- monitor_ready  out  1  JTAG command complete / idle
- monitor_error  out  1  sticky protocol error

Behaviour:
- Reset values: MonAReg=0, MonDReg=MONDREG_RST, monitor_ready=1, monitor_error=0, readdata=0, FSM=IDLE. RAM contents are not reset. Reset asserted mid-command aborts the command; no partial write occurs after the reset edge.
- jdo fields:
  - ocimem_a: jdo[36]=clear_error, jdo[35]=load_addr, jdo[34]=do_read, jdo[ADDR_W+16:17]=address.
  - ocimem_b: jdo[34:3]=write data.
- take_action_ocimem_a: if load_addr, MonAReg <= address field. If do_read, start a read at the resulting MonAReg. If neither bit is set, only the register update or error clear happens, and monitor_ready stays 1.
- take_no_action_ocimem_a: start a read at MonAReg.
- take_action_ocimem_b: start a write of the data field to MonAReg (all 4 byte lanes).
- Every read or write post-increments MonAReg by 1, taking effect on the ACCESS edge. MonAReg wraps from 2**ADDR_W-1 to 0.
- FSM:
  - IDLE -> ACCESS on an accepted strobe (edge E0); monitor_ready <= 0; command latched.
  - ACCESS: RAM addressed by MonAReg; write enable asserted for writes. -> CAPTURE at E1.
  - CAPTURE: MonDReg <= RAM q (read) or the written data (write); monitor_ready <= 1. -> IDLE at E2.
  - Total latency: strobe to monitor_ready high = 2 clocks.
- A strobe arriving while the FSM is not IDLE is dropped, and monitor_error <= 1.
- If more than one strobe is high in the same cycle: execute by priority b > a > no_action, and set monitor_error <= 1.
- monitor_error is cleared only by ocimem_a with clear_error=1. If a new error occurs in the same cycle as the clear, set wins.
- CPU side:
  - waitrequest = (FSM != IDLE) | any take_* strobe this cycle.
  - A read accepted (read & !waitrequest) at edge N drives readdata at N+1.
  - A write accepted with debugaccess=1 writes using byteenable.
  - A write with debugaccess=0 is accepted (no stall) and discarded.
  - read and write asserted together: write wins, readdata unchanged.
- RAM: a single-port synchronous 32-bit RAM with byte enables. The port mux selects JTAG in ACCESS, otherwise the CPU.

Decomposition:
- Shared package nios2_oci_pkg holds:
  - jdo field index constants (OCIMEM_CLR_ERR=36, OCIMEM_LD_ADDR=35, OCIMEM_RD=34, OCIMEM_ADDR_LSB=17, OCIMEM_WDATA_MSB=34, OCIMEM_WDATA_LSB=3);
  - the FSM state enum {IDLE, ACCESS, CAPTURE};
  - the command enum {CMD_RD, CMD_WR}.
- One sub-module: nios2_ocimem_ram, a single-port byte-enabled synchronous RAM parameterised by ADDR_W.

Test Plan:
- Reset: release reset_n -> MonAReg=0, MonDReg=0, monitor_ready=1, monitor_error=0, waitrequest=0.
- Write then read:
  - ocimem_a with jdo[35]=1, address=8'h10, then ocimem_b with data 32'hDEADBEEF -> monitor_ready low for 2 clocks; MonAReg=8'h11.
  - Then ocimem_a with load_addr=1, do_read=1, address=8'h10 -> MonDReg=32'hDEADBEEF two clocks after the strobe.
- Auto-increment and wrap: set MonAReg=8'hFF, pulse ocimem_b (data 32'h1) -> MonAReg=0; next no_action read returns ram[0].
- Collision:
  - pulse ocimem_b, then no_action one clock later -> second strobe is dropped, monitor_error=1.
  - ocimem_a with jdo[36]=1 -> monitor_error=0.
- CPU arbitration:
  - CPU read held during a JTAG write -> waitrequest=1 for 3 cycles (strobe, ACCESS, CAPTURE); then accepted, readdata returns the JTAG-written data 1 clock later.
  - CPU write with debugaccess=0 -> RAM unchanged.
- Reset during ACCESS of a write: assert reset_n=0 -> outputs return to reset values; a subsequent read of that word shows the old data.

Source files
------------

// File: rtl/nios2_oci_pkg.sv
// Shared OCI memory definitions: jdo field positions,
// controller FSM states and JTAG command types.
package nios2_oci_pkg;

  localparam int OCIMEM_CLR_ERR   = 36;
  localparam int OCIMEM_LD_ADDR   = 35;
  localparam int OCIMEM_RD        = 34;
  localparam int OCIMEM_ADDR_LSB  = 17;
  localparam int OCIMEM_WDATA_MSB = 34;
  localparam int OCIMEM_WDATA_LSB = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } cmd_t;

  typedef struct packed {
    cmd_t        op;
    logic [31:0] wdata;
  } ocimem_cmd_t;

endpackage

// File: rtl/nios2_ocimem_ctrl_if.sv
// CPU-side Avalon-MM bus to the OCI RAM.
// master drives address/read/write/data; slave returns readdata/waitrequest.
interface nios2_ocimem_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic              debugaccess;
  logic [31:0]       readdata;
  logic              waitrequest;

  modport master (
    output address, read, write,
    output writedata, byteenable, debugaccess,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write,
    input  writedata, byteenable, debugaccess,
    output readdata, waitrequest
  );
endinterface

// File: rtl/nios2_ocimem_ram.sv
// Single-port synchronous 32-bit RAM with byte enables.
// Ports: clk, addr, we, be, wdata in; q out (registered, old data on write).
module nios2_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/nios2_ocimem_ctrl.sv
// OCI debug memory controller: JTAG read/write via MonAReg/MonDReg,
// CPU Avalon slave (av) to the same RAM, JTAG has priority.
module nios2_ocimem_ctrl
  import nios2_oci_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter logic [31:0] MONDREG_RST = 32'h0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [37:0]        jdo,
  input  logic               take_action_ocimem_a,
  input  logic               take_action_ocimem_b,
  input  logic               take_no_action_ocimem_a,
  nios2_ocimem_ctrl_if.slave av,
  output logic [31:0]        MonDReg,
  output logic               monitor_ready,
  output logic               monitor_error
);

  state_t            state;
  state_t            state_nxt;
  ocimem_cmd_t       cmd_q;
  logic [ADDR_W-1:0] mon_a_reg;

  logic              stb_a;
  logic              stb_b;
  logic              stb_n;
  logic              sel_a;
  logic              sel_b;
  logic              sel_n;
  logic              any_stb;
  logic              multi_stb;
  logic              idle;
  logic              start;
  logic              err_set;
  logic              err_clr;

  logic              clr_err;
  logic              ld_addr;
  logic              do_read;
  logic [ADDR_W-1:0] j_addr;
  logic [31:0]       j_wdata;
  logic              unused_jdo;

  logic              jtag_port;
  logic              cap;
  logic              cpu_stall;
  logic              cpu_rd_acc;
  logic              cpu_wr_acc;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;

  logic              rd_pend;
  logic [31:0]       rd_hold;

  assign stb_a = take_action_ocimem_a;
  assign stb_b = take_action_ocimem_b;
  assign stb_n = take_no_action_ocimem_a;

  assign clr_err = jdo[OCIMEM_CLR_ERR];
  assign ld_addr = jdo[OCIMEM_LD_ADDR];
  assign do_read = jdo[OCIMEM_RD];
  assign j_addr  = jdo[OCIMEM_ADDR_LSB +: ADDR_W];
  assign j_wdata = jdo[OCIMEM_WDATA_MSB:OCIMEM_WDATA_LSB];

  assign unused_jdo =
    ^{jdo[37], jdo[OCIMEM_WDATA_LSB-1:0]};

  // Simultaneous strobes resolve b > a > no_action.
  assign sel_b = stb_b;
  assign sel_a = stb_a & ~stb_b;
  assign sel_n = stb_n & ~stb_a & ~stb_b;

  assign any_stb   = stb_a | stb_b | stb_n;
  assign multi_stb = (stb_a & stb_b)
                   | (stb_a & stb_n)
                   | (stb_b & stb_n);

  assign idle  = (state == IDLE);
  assign start = idle
               & (sel_b | sel_n | (sel_a & do_read));

  // Busy drop or collision sets; set beats clear.
  assign err_set = any_stb & (~idle | multi_stb);
  assign err_clr = idle & sel_a & clr_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ACCESS;
      ACCESS:  state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_stall = ~idle | any_stb;
  assign cpu_wr_acc = av.write & ~cpu_stall;
  assign cpu_rd_acc = av.read & ~av.write & ~cpu_stall;

  always_comb begin
    jtag_port = 1'b0;
    cap       = 1'b0;
    unique case (state)
      ACCESS:  jtag_port = 1'b1;
      CAPTURE: cap       = 1'b1;
      default: ;
    endcase

    if (jtag_port) begin
      ram_addr  = mon_a_reg;
      ram_we    = (cmd_q.op == CMD_WR);
      ram_be    = 4'hF;
      ram_wdata = cmd_q.wdata;
    end else begin
      ram_addr  = av.address;
      ram_we    = cpu_wr_acc & av.debugaccess;
      ram_be    = av.byteenable;
      ram_wdata = av.writedata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q <= '0;
    end else if (start) begin
      cmd_q.op    <= sel_b ? CMD_WR : CMD_RD;
      cmd_q.wdata <= j_wdata;
    end
  end

  // Load happens at the strobe edge, so a combined
  // load+read accesses the new address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_a_reg <= '0;
    end else if (jtag_port) begin
      mon_a_reg <= mon_a_reg + ADDR_W'(1);
    end else if (idle && sel_a && ld_addr) begin
      mon_a_reg <= j_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MonDReg       <= MONDREG_RST;
      monitor_ready <= 1'b1;
    end else if (start) begin
      monitor_ready <= 1'b0;
    end else if (cap) begin
      monitor_ready <= 1'b1;
      MonDReg       <= (cmd_q.op == CMD_WR)
                     ? cmd_q.wdata : ram_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      monitor_error <= 1'b0;
    end else if (err_set) begin
      monitor_error <= 1'b1;
    end else if (err_clr) begin
      monitor_error <= 1'b0;
    end
  end

  // RAM q is valid the cycle after acceptance; hold it
  // afterwards so readdata only changes on a new read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend <= 1'b0;
      rd_hold <= '0;
    end else begin
      rd_pend <= cpu_rd_acc;
      if (rd_pend) rd_hold <= ram_q;
    end
  end

  assign av.readdata    = rd_pend ? ram_q : rd_hold;
  assign av.waitrequest = cpu_stall;

  nios2_ocimem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_nios2_ocimem_ctrl.sv
// Self-checking bench for nios2_ocimem_ctrl: vector table,
// directed corner sequences and random traffic vs a command-level model.
module tb_nios2_ocimem_ctrl;

  localparam int AW = 8;

  typedef struct {
    logic        a;
    logic        b;
    logic        n;
    logic [37:0] j;
    logic        busy;
    logic [31:0] d;
    logic        e;
  } vec_t;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo     = '0;
  logic        ta      = 1'b0;
  logic        tb_     = 1'b0;
  logic        tn      = 1'b0;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  nios2_ocimem_ctrl_if #(.ADDR_W(AW)) av ();

  nios2_ocimem_ctrl #(
    .ADDR_W      (AW),
    .MONDREG_RST (32'h0)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta),
    .take_action_ocimem_b    (tb_),
    .take_no_action_ocimem_a (tn),
    .av                      (av),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  logic [31:0] m_mem [256];
  logic [7:0]  m_areg;
  logic [31:0] m_dreg;
  logic [31:0] m_rdata;
  logic        m_err;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  vec_t vt [14];
  int   lat;
  int   cnt;
  logic busy;
  logic [37:0] jw;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] iv(input int i);
    return 32'hCAFE0000 | 32'(i);
  endfunction

  function automatic logic [37:0] mk_a(input logic clr,
                                       input logic ld,
                                       input logic rd,
                                       input logic [7:0] ad);
    logic [37:0] j;
    j = '0;
    j[36] = clr;
    j[35] = ld;
    j[34] = rd;
    j[24:17] = ad;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // Command-level model: effect of one JTAG cycle issued while idle.
  task automatic model_cmd(input logic a, input logic b,
                           input logic n,
                           input logic [37:0] j,
                           output logic bz);
    int k;
    k  = int'(a) + int'(b) + int'(n);
    bz = 1'b0;
    if (b) begin
      m_mem[m_areg] = j[34:3];
      m_dreg = j[34:3];
      m_areg = m_areg + 8'd1;
      bz = 1'b1;
    end else if (a) begin
      if (j[35]) m_areg = j[24:17];
      if (j[34]) begin
        m_dreg = m_mem[m_areg];
        m_areg = m_areg + 8'd1;
        bz = 1'b1;
      end
    end else if (n) begin
      m_dreg = m_mem[m_areg];
      m_areg = m_areg + 8'd1;
      bz = 1'b1;
    end
    if (k > 1) m_err = 1'b1;
    else if (a && j[36]) m_err = 1'b0;
  endtask

  task automatic jtag_drive(input logic a, input logic b,
                            input logic n,
                            input logic [37:0] j,
                            output int lt);
    jdo = j;
    ta  = a;
    tb_ = b;
    tn  = n;
    tick;
    ta  = 1'b0;
    tb_ = 1'b0;
    tn  = 1'b0;
    jdo = '0;
    lt  = 0;
    while (!monitor_ready && lt < 10) begin
      tick;
      lt++;
    end
  endtask

  task automatic jtag_chk(input string nm, input logic a,
                          input logic b, input logic n,
                          input logic [37:0] j);
    int   lt;
    logic bz;
    jtag_drive(a, b, n, j, lt);
    model_cmd(a, b, n, j, bz);
    chk({nm, "_lat"}, 32'(lt), bz ? 32'd2 : 32'd0);
    chk({nm, "_dreg"}, MonDReg, m_dreg);
    chk({nm, "_err"}, 32'(monitor_error), 32'(m_err));
  endtask

  task automatic cpu_write(input logic [7:0] ad,
                           input logic [31:0] d,
                           input logic [3:0] be,
                           input logic dbg);
    av.address     = ad;
    av.writedata   = d;
    av.byteenable  = be;
    av.debugaccess = dbg;
    av.write       = 1'b1;
    tick;
    av.write = 1'b0;
    if (dbg) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) m_mem[ad][8*k +: 8] = d[8*k +: 8];
      end
    end
  endtask

  task automatic cpu_read(input string nm,
                          input logic [7:0] ad);
    av.address = ad;
    av.read    = 1'b1;
    tick;
    av.read = 1'b0;
    m_rdata = m_mem[ad];
    chk(nm, av.readdata, m_rdata);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    av.read        = 1'b0;
    av.write       = 1'b0;
    av.address     = '0;
    av.writedata   = '0;
    av.byteenable  = '0;
    av.debugaccess = 1'b0;
    m_areg  = '0;
    m_dreg  = '0;
    m_rdata = '0;
    m_err   = 1'b0;

    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    chk("rst_dreg", MonDReg, 32'h0);
    chk("rst_ready", 32'(monitor_ready), 32'd1);
    chk("rst_err", 32'(monitor_error), 32'd0);
    chk("rst_wait", 32'(av.waitrequest), 32'd0);
    chk("rst_rdata", av.readdata, 32'h0);
    tick;

    for (int i = 0; i < 256; i++) begin
      cpu_write(8'(i), iv(i), 4'hF, 1'b1);
    end

    jw = mk_b(32'h12345678);
    jw[35] = 1'b1;
    vt[0]  = '{1'b0, 1'b0, 1'b1, 38'd0,
               1'b1, 32'hCAFE0000, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, mk_a(0, 1, 0, 8'h10),
               1'b0, 32'hCAFE0000, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 1'b0, mk_b(32'hDEADBEEF),
               1'b1, 32'hDEADBEEF, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 38'd0,
               1'b1, 32'hCAFE0011, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, mk_a(0, 1, 1, 8'h10),
               1'b1, 32'hDEADBEEF, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 1'b0, mk_a(0, 1, 0, 8'hFF),
               1'b0, 32'hDEADBEEF, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b0, mk_b(32'h1),
               1'b1, 32'h00000001, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 38'd0,
               1'b1, 32'hCAFE0000, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 38'd0,
               1'b1, 32'hCAFE0001, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 1'b0, jw,
               1'b1, 32'h12345678, 1'b1};
    vt[10] = '{1'b0, 1'b0, 1'b1, 38'd0,
               1'b1, 32'hCAFE0003, 1'b1};
    vt[11] = '{1'b1, 1'b0, 1'b0, mk_a(1, 1, 1, 8'h02),
               1'b1, 32'h12345678, 1'b0};
    vt[12] = '{1'b1, 1'b0, 1'b1, mk_a(0, 1, 1, 8'h10),
               1'b1, 32'hDEADBEEF, 1'b1};
    vt[13] = '{1'b1, 1'b0, 1'b0, mk_a(1, 0, 0, 8'h00),
               1'b0, 32'hDEADBEEF, 1'b0};

    for (int i = 0; i < 14; i++) begin
      jtag_drive(vt[i].a, vt[i].b, vt[i].n, vt[i].j, lat);
      model_cmd(vt[i].a, vt[i].b, vt[i].n, vt[i].j, busy);
      chk($sformatf("vec%0d_lat", i), 32'(lat),
          vt[i].busy ? 32'd2 : 32'd0);
      chk($sformatf("vec%0d_dreg", i), MonDReg, vt[i].d);
      chk($sformatf("vec%0d_err", i),
          32'(monitor_error), 32'(vt[i].e));
    end

    // Strobe while busy is dropped and flags an error.
    jw = mk_b(32'hA1B2C3D4);
    jdo = jw;
    tb_ = 1'b1;
    tick;
    tb_ = 1'b0;
    jdo = '0;
    tn  = 1'b1;
    tick;
    tn  = 1'b0;
    lat = 0;
    while (!monitor_ready && lat < 10) begin
      tick;
      lat++;
    end
    model_cmd(1'b0, 1'b1, 1'b0, jw, busy);
    m_err = 1'b1;
    chk("coll_lat", 32'(lat), 32'd1);
    chk("coll_dreg", MonDReg, m_dreg);
    chk("coll_err", 32'(monitor_error), 32'd1);
    jtag_chk("clr", 1'b1, 1'b0, 1'b0, mk_a(1, 0, 0, 8'h00));
    jtag_chk("coll_next", 1'b0, 1'b0, 1'b1, 38'd0);

    // CPU read stalls behind a JTAG write.
    av.address = m_areg;
    av.read    = 1'b1;
    jw  = mk_b(32'h0BADF00D);
    jdo = jw;
    tb_ = 1'b1;
    #1;
    cnt = 0;
    while (av.waitrequest && cnt < 10) begin
      cnt++;
      tick;
      tb_ = 1'b0;
      jdo = '0;
    end
    chk("arb_wait", 32'(cnt), 32'd3);
    model_cmd(1'b0, 1'b1, 1'b0, jw, busy);
    tick;
    av.read = 1'b0;
    m_rdata = 32'h0BADF00D;
    chk("arb_rdata", av.readdata, m_rdata);
    chk("arb_dreg", MonDReg, m_dreg);

    cpu_write(8'h20, 32'hFFFFFFFF, 4'hF, 1'b0);
    cpu_read("nodbg_rd", 8'h20);
    cpu_write(8'h21, 32'h11223344, 4'b0101, 1'b1);
    cpu_read("be_rd", 8'h21);

    // Read and write together: write wins, readdata holds.
    av.address     = 8'h22;
    av.writedata   = 32'h77777777;
    av.byteenable  = 4'hF;
    av.debugaccess = 1'b1;
    av.read        = 1'b1;
    av.write       = 1'b1;
    tick;
    av.read  = 1'b0;
    av.write = 1'b0;
    m_mem[8'h22] = 32'h77777777;
    chk("rw_hold", av.readdata, m_rdata);
    cpu_read("rw_rd", 8'h22);

    // Reset in the middle of a JTAG write.
    jtag_chk("an_ld", 1'b1, 1'b0, 1'b1, mk_a(0, 1, 0, 8'h30));
    jdo = mk_b(32'h99999999);
    tb_ = 1'b1;
    tick;
    tb_ = 1'b0;
    jdo = '0;
    reset_n = 1'b0;
    #2;
    chk("mrst_dreg", MonDReg, 32'h0);
    chk("mrst_ready", 32'(monitor_ready), 32'd1);
    chk("mrst_err", 32'(monitor_error), 32'd0);
    chk("mrst_wait", 32'(av.waitrequest), 32'd0);
    chk("mrst_rdata", av.readdata, 32'h0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    tick;
    m_areg  = '0;
    m_dreg  = '0;
    m_err   = 1'b0;
    m_rdata = '0;
    cpu_read("mrst_word", 8'h30);
    jtag_chk("mrst_n", 1'b0, 1'b0, 1'b1, 38'd0);

    for (int i = 0; i < 400; i++) begin
      int          r;
      int          s;
      logic [37:0] j;
      r = $urandom_range(0, 9);
      if (r < 5) begin
        j = 38'({$urandom, $urandom});
        if ($urandom_range(0, 3) == 0) begin
          s = $urandom_range(1, 7);
        end else begin
          s = 1 << $urandom_range(0, 2);
        end
        jtag_chk($sformatf("rnd%0d_j", i),
                 s[0], s[1], s[2], j);
      end else if (r < 8) begin
        cpu_write(8'($urandom), $urandom,
                  4'($urandom), 1'($urandom));
      end else begin
        cpu_read($sformatf("rnd%0d_rd", i), 8'($urandom));
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
